regbank_wb_arbiter: RTL and testbench
=====================================

# regbank_wb_arbiter

Write-back arbiter for the 32-entry register bank. Shares the bank's single write port among four requesters: ALU result, memory load, multiplier (low/high pair) and link-address write. It grants one requester per cycle with round-robin fairness and drives a registered write command (RegWrite code, address and data buses) into the bank. It sits between the execute/memory stages and the register bank's write inputs.

## Interface
- No parameters; widths are fixed (5-bit register address, 32-bit data, 4 requesters).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- hold  in  1  when 1, no grants are issued this cycle
- alu_valid / alu_ready  in / out  1 / 1  ALU write request / grant
- alu_addr, alu_data  in  5, 32  ALU destination and result
- mem_valid / mem_ready  in / out  1 / 1  load write request / grant
- mem_addr, mem_data  in  5, 32  load destination and data
- mul_valid / mul_ready  in / out  1 / 1  multiplier write request / grant
- mul_addr, mul_lo, mul_hi  in  5, 32, 32  destination, low word, high word
- link_valid / link_ready  in / out  1 / 1  link-address write request / grant
- link_data  in  32  return address
- RegWrite  out  2  write command: 0 none, 1 single write, 2 write plus high, 3 link write
- writeAdd  out  5  write address
- writeData  out  32  write data
- highData  out  32  high-word data (code 2)
- raDataIn  out  32  link data (code 3)
- last_grant  out  2  index of the most recent grant (0 ALU, 1 MEM, 2 MUL, 3 LINK)

## Operation
- Arbitration: combinational in the request cycle. Search order starts at last_grant+1 (mod 4) and wraps; the first valid requester is granted. At most one ready is high per cycle.
- ready[i] = valid[i] & chosen[i] & ~hold & rst. ready depends combinationally on valid. A transfer occurs when valid & ready are both high at a rising edge.
- last_grant updates to the granted index on every transfer. It is unchanged when there is no transfer, hold=1 or all valid are low.
- Command encoding, registered on the transfer edge:
  - ALU or MEM: RegWrite=1, writeAdd=addr, writeData=data.
  - MUL: RegWrite=2, writeAdd=mul_addr, writeData=mul_lo, highData=mul_hi.
  - LINK: RegWrite=3, writeAdd=5'd31, raDataIn=link_data, writeData=0.
- Zero-register suppression: an ALU or MEM transfer with addr=0 is still accepted and still updates last_grant. It drives RegWrite=0 and writeAdd=0, with writeData loaded as normal. MUL with mul_addr=0 still issues code 2, because the high write remains meaningful.
- On a cycle with no transfer, RegWrite returns to 0. writeAdd, writeData, highData and raDataIn hold their last values.
- Requesters must hold their valid and payload until ready. The arbiter never drops an accepted request and never issues an unaccepted one.

## Timing
- Reset: synchronous, when rst=0 at a rising edge. It sets RegWrite=0, writeAdd=0, writeData=0, highData=0, raDataIn=0 and last_grant=3, so ALU has first priority after reset. All ready outputs are forced to 0 while rst=0.
- A request arriving during reset is not accepted. It is granted normally on the first edge after rst returns to 1.
- Latency: transfer at edge N puts the command on the outputs after edge N. The bank writes it at edge N+1. RegWrite is a one-cycle pulse per transfer.
- Throughput: one transfer per cycle. Back-to-back grants produce back-to-back RegWrite pulses with no bubble.
- With all four requesters continuously valid, grants rotate 0,1,2,3,0,… Each requester waits at most 3 cycles after becoming eligible.
- hold=1: no ready outputs and no transfer. RegWrite=0 on the following cycle. last_grant is unchanged.
- When hold deasserts, arbitration resumes from the preserved last_grant.

## Test plan
- Reset then single ALU write: alu_valid=1, addr=8, data=18 → alu_ready=1 that cycle. Next cycle RegWrite=1, writeAdd=8, writeData=18. Following cycle RegWrite=0.
- All four valid for 8 cycles after reset → grant order ALU, MEM, MUL, LINK, ALU, MEM, MUL, LINK. RegWrite sequence is 1,1,2,3,1,1,2,3 with no idle cycle.
- MUL: mul_addr=5, lo=32'h1234, hi=32'hFFFF_0001 → RegWrite=2, writeAdd=5, writeData=32'h1234, highData=32'hFFFF_0001.
- LINK with link_data=32'h0000_0040 → RegWrite=3, writeAdd=31, raDataIn=32'h40.
- ALU with addr=0 → alu_ready=1, then RegWrite=0 and writeAdd=0. last_grant=0.
- hold=1 for 3 cycles with MEM and MUL valid → no ready, RegWrite stays 0, last_grant unchanged.
- Release hold, then assert rst=0 for one cycle mid-stream → ready outputs 0 during reset. All outputs cleared. The next grant after reset goes to the lowest valid index starting at ALU.

Source files
------------

// File: rtl/regbank_wb_arbiter_if.sv
// Write-back request/grant bundle between the four
// requesters and the register-bank write-port arbiter.
interface regbank_wb_arbiter_if;
  logic        hold;

  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;

  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_addr;
  logic [31:0] mul_lo;
  logic [31:0] mul_hi;

  logic        link_valid;
  logic        link_ready;
  logic [31:0] link_data;

  logic [1:0]  RegWrite;
  logic [4:0]  writeAdd;
  logic [31:0] writeData;
  logic [31:0] highData;
  logic [31:0] raDataIn;
  logic [1:0]  last_grant;

  modport slave (
    input  hold,
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  mul_valid, mul_addr, mul_lo, mul_hi,
    input  link_valid, link_data,
    output alu_ready, mem_ready,
    output mul_ready, link_ready,
    output RegWrite, writeAdd, writeData,
    output highData, raDataIn, last_grant
  );

  modport master (
    output hold,
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output mul_valid, mul_addr, mul_lo, mul_hi,
    output link_valid, link_data,
    input  alu_ready, mem_ready,
    input  mul_ready, link_ready,
    input  RegWrite, writeAdd, writeData,
    input  highData, raDataIn, last_grant
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin write-back arbiter for the register bank.
// Ports: clk, rst (sync, active-low), bus (slave modport).
module regbank_wb_arbiter (
  input  logic clk,
  input  logic rst,
  regbank_wb_arbiter_if.slave bus
);
  logic [3:0] valid;
  logic [3:0] chosen;
  logic [3:0] ready;
  logic [1:0] idx;

  assign valid = {bus.link_valid, bus.mul_valid,
                  bus.mem_valid, bus.alu_valid};

  // Search starts one past the previous winner and
  // wraps, so 2-bit addition gives the modulo for free.
  always_comb begin
    chosen = '0;
    idx    = '0;
    for (int k = 1; k < 5; k++) begin
      idx = bus.last_grant + 2'(k);
      if (chosen == '0 && valid[idx])
        chosen[idx] = 1'b1;
    end
  end

  assign ready = chosen & {4{~bus.hold & rst}};

  assign bus.alu_ready  = ready[0];
  assign bus.mem_ready  = ready[1];
  assign bus.mul_ready  = ready[2];
  assign bus.link_ready = ready[3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.RegWrite   <= 2'd0;
      bus.writeAdd   <= 5'd0;
      bus.writeData  <= 32'd0;
      bus.highData   <= 32'd0;
      bus.raDataIn   <= 32'd0;
      bus.last_grant <= 2'd3;
    end else begin
      bus.RegWrite <= 2'd0;
      unique case (1'b1)
        ready[0]: begin
          bus.last_grant <= 2'd0;
          // x0 writes are accepted but not issued
          bus.RegWrite   <= (bus.alu_addr != 5'd0)
                            ? 2'd1 : 2'd0;
          bus.writeAdd   <= bus.alu_addr;
          bus.writeData  <= bus.alu_data;
        end
        ready[1]: begin
          bus.last_grant <= 2'd1;
          bus.RegWrite   <= (bus.mem_addr != 5'd0)
                            ? 2'd1 : 2'd0;
          bus.writeAdd   <= bus.mem_addr;
          bus.writeData  <= bus.mem_data;
        end
        ready[2]: begin
          // high word still lands even for x0
          bus.last_grant <= 2'd2;
          bus.RegWrite   <= 2'd2;
          bus.writeAdd   <= bus.mul_addr;
          bus.writeData  <= bus.mul_lo;
          bus.highData   <= bus.mul_hi;
        end
        ready[3]: begin
          bus.last_grant <= 2'd3;
          bus.RegWrite   <= 2'd3;
          bus.writeAdd   <= 5'd31;
          bus.writeData  <= 32'd0;
          bus.raDataIn   <= bus.link_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed steps then
// random traffic against a behavioural model.
module tb_regbank_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regbank_wb_arbiter_if bus ();

  regbank_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int          m_lg = 3;
  logic [1:0]  m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_hd, m_ra;
  int          last_g = -1;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    logic [3:0] v;
    v = {bus.link_valid, bus.mul_valid,
         bus.mem_valid, bus.alu_valid};
    if (bus.hold !== 1'b0 || rst !== 1'b1) return -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_lg + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [3:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("ready", {28'b0, bus.link_ready, bus.mul_ready,
                  bus.mem_ready, bus.alu_ready},
        {28'b0, er});
    last_g = g;
    @(posedge clk);
    if (rst !== 1'b1) begin
      m_lg = 3; m_rw = 0; m_wa = 0;
      m_wd = 0; m_hd = 0; m_ra = 0;
    end else begin
      m_rw = 0;
      if (g >= 0) m_lg = g;
      if (g == 0) begin
        m_wa = bus.alu_addr;
        m_wd = bus.alu_data;
        m_rw = (m_wa == 0) ? 2'd0 : 2'd1;
      end else if (g == 1) begin
        m_wa = bus.mem_addr;
        m_wd = bus.mem_data;
        m_rw = (m_wa == 0) ? 2'd0 : 2'd1;
      end else if (g == 2) begin
        m_rw = 2; m_wa = bus.mul_addr;
        m_wd = bus.mul_lo; m_hd = bus.mul_hi;
      end else if (g == 3) begin
        m_rw = 3; m_wa = 31;
        m_wd = 0; m_ra = bus.link_data;
      end
    end
    #1;
    chk("RegWrite", 32'(bus.RegWrite), 32'(m_rw));
    chk("writeAdd", 32'(bus.writeAdd), 32'(m_wa));
    chk("writeData", bus.writeData, m_wd);
    chk("highData", bus.highData, m_hd);
    chk("raDataIn", bus.raDataIn, m_ra);
    chk("last_grant", 32'(bus.last_grant), 32'(m_lg));
  endtask

  task automatic idle();
    bus.hold = 0;
    bus.alu_valid = 0; bus.alu_addr = 0;
    bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_addr = 0;
    bus.mem_data = 0;
    bus.mul_valid = 0; bus.mul_addr = 0;
    bus.mul_lo = 0; bus.mul_hi = 0;
    bus.link_valid = 0; bus.link_data = 0;
  endtask

  task automatic rnd_req(int i);
    logic v;
    v = ($urandom_range(0, 2) != 0);
    case (i)
      0: begin
        bus.alu_valid = v;
        bus.alu_addr  = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      1: begin
        bus.mem_valid = v;
        bus.mem_addr  = 5'($urandom_range(0, 31));
        bus.mem_data  = $urandom;
      end
      2: begin
        bus.mul_valid = v;
        bus.mul_addr  = 5'($urandom_range(0, 31));
        bus.mul_lo    = $urandom;
        bus.mul_hi    = $urandom;
      end
      default: begin
        bus.link_valid = v;
        bus.link_data  = $urandom;
      end
    endcase
  endtask

  initial begin
    logic [3:0] vs;
    idle();
    rst = 1'b0;
    step();
    step();
    chk("rst_lg", 32'(bus.last_grant), 32'd3);
    rst = 1'b1;

    bus.alu_valid = 1; bus.alu_addr = 8;
    bus.alu_data = 18;
    step();
    chk("t1_grant", 32'(last_g), 32'd0);
    chk("t1_rw", 32'(bus.RegWrite), 32'd1);
    chk("t1_wa", 32'(bus.writeAdd), 32'd8);
    chk("t1_wd", bus.writeData, 32'd18);
    bus.alu_valid = 0;
    step();
    chk("t1_rw0", 32'(bus.RegWrite), 32'd0);

    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.alu_valid = 1;  bus.alu_addr = 3;
    bus.mem_valid = 1;  bus.mem_addr = 4;
    bus.mul_valid = 1;  bus.mul_addr = 6;
    bus.link_valid = 1;
    for (int i = 0; i < 8; i++) begin
      int er;
      step();
      er = (i % 4 == 2) ? 2 : (i % 4 == 3) ? 3 : 1;
      chk("rot_grant", 32'(last_g), 32'(i % 4));
      chk("rot_rw", 32'(bus.RegWrite), 32'(er));
    end
    idle();

    bus.mul_valid = 1; bus.mul_addr = 5;
    bus.mul_lo = 32'h1234; bus.mul_hi = 32'hFFFF_0001;
    step();
    chk("mul_rw", 32'(bus.RegWrite), 32'd2);
    chk("mul_wa", 32'(bus.writeAdd), 32'd5);
    chk("mul_wd", bus.writeData, 32'h1234);
    chk("mul_hd", bus.highData, 32'hFFFF_0001);
    idle();

    bus.link_valid = 1; bus.link_data = 32'h40;
    step();
    chk("lnk_rw", 32'(bus.RegWrite), 32'd3);
    chk("lnk_wa", 32'(bus.writeAdd), 32'd31);
    chk("lnk_ra", bus.raDataIn, 32'h40);
    idle();

    bus.alu_valid = 1; bus.alu_addr = 0;
    bus.alu_data = 32'h77;
    step();
    chk("x0_grant", 32'(last_g), 32'd0);
    chk("x0_rw", 32'(bus.RegWrite), 32'd0);
    chk("x0_wa", 32'(bus.writeAdd), 32'd0);
    chk("x0_lg", 32'(bus.last_grant), 32'd0);
    idle();

    bus.hold = 1;
    bus.mem_valid = 1; bus.mem_addr = 9;
    bus.mem_data = 32'hAA;
    bus.mul_valid = 1; bus.mul_addr = 10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rdy", {31'b0, bus.mem_ready |
                       bus.mul_ready}, 32'd0);
      chk("hold_rw", 32'(bus.RegWrite), 32'd0);
      chk("hold_lg", 32'(bus.last_grant), 32'd0);
    end
    bus.hold = 0;
    step();
    chk("rel_grant", 32'(last_g), 32'd1);

    rst = 1'b0;
    step();
    chk("rst2_rw", 32'(bus.RegWrite), 32'd0);
    chk("rst2_wd", bus.writeData, 32'd0);
    chk("rst2_lg", 32'(bus.last_grant), 32'd3);
    rst = 1'b1;
    step();
    chk("post_grant", 32'(last_g), 32'd1);
    idle();

    for (int n = 0; n < 600; n++) begin
      vs = {bus.link_valid, bus.mul_valid,
            bus.mem_valid, bus.alu_valid};
      for (int i = 0; i < 4; i++)
        if (!(vs[i] && last_g != i)) continue;
        else vs[i] = 1'b1;
      for (int i = 0; i < 4; i++)
        if (!(vs[i] && last_g != i)) rnd_req(i);
      bus.hold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
